// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: sizes, field widths and
// the 2-bit prediction counter encoding.
package branch_target_buffer_pkg;

  localparam int unsigned DefaultEntries = 8;
  localparam int unsigned PcW            = 32;
  localparam int unsigned TargetW        = 32;
  localparam int unsigned CntBits        = 2;

  // 2-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [CntBits-1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } bp_cnt_e;

  // Counter value given to a freshly allocated entry.
  localparam bp_cnt_e CntAlloc = CntWt;

  // Index width for a direct-mapped table of the given size.
  function automatic int unsigned index_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag covers every PC bit above the index; pc[1:0] is never stored.
  function automatic int unsigned tag_w(input int unsigned entries);
    return PcW - index_w(entries) - 2;
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  bp_cnt_e cnt_cur;

  assign cnt_cur = bp_cnt_e'(cnt_i);

  // Step toward strongly-taken on taken, toward strongly-not-taken otherwise.
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_cur != CntSt) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_cur != CntSnt) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters, updated
// from the EX stage, plus a registered mispredict pulse and saturating count.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES = DefaultEntries,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // fetch-side lookup
  input  logic [31:0]      if_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_next_pc,
  // EX-side resolution
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_next_pc,
  input  logic             flush_all,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned IW = index_w(ENTRIES);
  localparam int unsigned TW = tag_w(ENTRIES);

  logic                   valid_q  [ENTRIES];
  logic [TW-1:0]          tag_q    [ENTRIES];
  logic [TargetW-1:0]     target_q [ENTRIES];
  logic [CntBits-1:0]     cnt_q    [ENTRIES];

  logic [IW-1:0]          if_idx;
  logic [TW-1:0]          if_tag;
  logic [IW-1:0]          ex_idx;
  logic [TW-1:0]          ex_tag;
  logic                   ex_hit;
  logic [CntBits-1:0]     cnt_upd;
  logic                   mismatch;
  logic                   mispredict_q;
  logic [CNT_W-1:0]       mispredict_cnt_q;
  logic [CNT_W-1:0]       mispredict_cnt_d;
  logic                   unused_pc_lsbs;

  assign if_idx = if_pc[IW+1:2];
  assign if_tag = if_pc[31:IW+2];
  assign ex_idx = ex_pc[IW+1:2];
  assign ex_tag = ex_pc[31:IW+2];

  // Instruction fetch is word aligned; the low PC bits carry no information.
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads current state only; an update in flight is not bypassed.
  always_comb begin
    pred_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken   = pred_hit && cnt_q[if_idx][1];
    pred_next_pc = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);
  end

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_counter2 u_sat_counter2 (
    .cnt_i   (cnt_q[ex_idx]),
    .taken_i (ex_taken),
    .cnt_o   (cnt_upd)
  );

  // Table state: flush beats any same-cycle update; misses allocate only if taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        cnt_q[ex_idx] <= cnt_upd;
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        cnt_q[ex_idx]    <= CntAlloc;
      end
    end
  end

  // A taken branch must have been predicted to its real target; a not-taken
  // one must have been predicted not-taken and to the fall-through PC.
  always_comb begin
    if (ex_taken) begin
      mismatch = (ex_pred_next_pc != ex_target);
    end else begin
      mismatch = ex_pred_taken || (ex_pred_next_pc != (ex_pc + 32'd4));
    end
  end

  // Saturating mispredict count; advances on the same edge the pulse rises.
  always_comb begin
    mispredict_cnt_d = mispredict_cnt_q;
    if (ex_valid && mismatch && (mispredict_cnt_q != '1)) begin
      mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
  end

  // Mispredict pulse and count registers; flush does not touch the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q     <= 1'b0;
      mispredict_cnt_q <= '0;
    end else begin
      mispredict_q     <= ex_valid && mismatch;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign mispredict     = mispredict_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (8 entries, 4-bit mispredict count).
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_next_pc;
  logic        flush_all;
  logic        mispredict;
  logic [3:0]  mispredict_cnt;

  int n_cmp;
  int n_err;

  branch_target_buffer #(
    .ENTRIES (8),
    .CNT_W   (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_pc           (if_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_next_pc    (pred_next_pc),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_taken        (ex_taken),
    .ex_target       (ex_target),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_next_pc (ex_pred_next_pc),
    .flush_all       (flush_all),
    .mispredict      (mispredict),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Check the combinational lookup result for one fetch PC.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tkn, input logic [31:0] nxt);
    if_pc = pc;
    #1;
    chk({tag, "_hit"}, 32'(pred_hit), 32'(hit));
    chk({tag, "_tkn"}, 32'(pred_taken), 32'(tkn));
    chk({tag, "_nxt"}, pred_next_pc, nxt);
  endtask

  // Present one resolved branch for a single clock, then drop ex_valid.
  task automatic resolve(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt,
                         input logic ptkn, input logic [31:0] pnxt, input logic flush);
    ex_valid        = 1'b1;
    ex_pc           = pc;
    ex_taken        = tkn;
    ex_target       = tgt;
    ex_pred_taken   = ptkn;
    ex_pred_next_pc = pnxt;
    flush_all       = flush;
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    flush_all = 1'b0;
  endtask

  // Post-resolve registered outputs.
  task automatic mp(input string tag, input logic pulse, input logic [3:0] cnt);
    chk({tag, "_mp"}, 32'(mispredict), 32'(pulse));
    chk({tag, "_cnt"}, 32'(mispredict_cnt), 32'(cnt));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    if_pc = 32'h0040_0010;
    ex_valid = 1'b0;
    ex_pc = '0;
    ex_taken = 1'b0;
    ex_target = '0;
    ex_pred_taken = 1'b0;
    ex_pred_next_pc = '0;
    flush_all = 1'b0;

    // Reset state, during and after reset
    look("rst_in", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    mp("rst_in", 1'b0, 4'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("rst_out", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    mp("rst_out", 1'b0, 4'd0);

    // First taken resolution allocates; same-cycle lookup still misses
    ex_valid = 1'b1; ex_pc = 32'h0040_0010; ex_taken = 1'b1; ex_target = 32'h0040_0100;
    ex_pred_taken = 1'b0; ex_pred_next_pc = 32'h0040_0014;
    look("nobyp", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    mp("alloc", 1'b1, 4'd1);
    look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    @(posedge clk);
    #1;
    mp("idle", 1'b0, 4'd1);

    // Not taken twice, correctly predicted: 10 -> 01 -> 00, target kept
    resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014, 1'b0);
    mp("nt1", 1'b0, 4'd1);
    look("nt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0, 32'h0040_0014, 1'b0);
    look("nt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

    // Taken with new target: 00 -> 01 (still not taken) -> 10 (taken, new target)
    resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200, 1'b0);
    mp("t1", 1'b0, 4'd1);
    look("t1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200, 1'b0);
    look("t2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);

    // Saturate at 11: two more taken, then one not-taken leaves it taken (10)
    resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200, 1'b0);
    resolve(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200, 1'b0);
    resolve(32'h0040_0010, 1'b0, 32'h0040_0200, 1'b0, 32'h0040_0014, 1'b0);
    look("sat3", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    resolve(32'h0040_0010, 1'b0, 32'h0040_0200, 1'b0, 32'h0040_0014, 1'b0);
    look("sat3b", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

    // Alias at the same index replaces the entry
    resolve(32'h0040_0030, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0034, 1'b0);
    mp("alias", 1'b1, 4'd2);
    look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    look("alias_new", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300);

    // Not-taken miss does not allocate; wrong fall-through PC is a mispredict
    resolve(32'h0040_0044, 1'b0, 32'h0040_0500, 1'b0, 32'h0040_0999, 1'b0);
    mp("ntmiss", 1'b1, 4'd3);
    look("ntmiss", 32'h0040_0044, 1'b0, 1'b0, 32'h0040_0048);

    // Flush with a simultaneous taken update: everything misses, count held
    resolve(32'h0040_0058, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400, 1'b1);
    mp("flush", 1'b0, 4'd3);
    look("flush_a", 32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
    look("flush_b", 32'h0040_0058, 1'b0, 1'b0, 32'h0040_005c);

    // 20 back-to-back mispredicts: count climbs from 3 and sticks at 0xF
    ex_valid = 1'b1; ex_pc = 32'h0040_0060; ex_taken = 1'b0; ex_target = 32'h0;
    ex_pred_taken = 1'b1; ex_pred_next_pc = 32'h0040_0064;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      mp("satcnt", 1'b1, (i + 4 > 15) ? 4'hf : 4'(i + 4));
    end
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    mp("satcnt_end", 1'b0, 4'hf);

    // Reset arriving mid-update: no entry survives, counters cleared at once
    ex_valid = 1'b1; ex_pc = 32'h0040_0070; ex_taken = 1'b1; ex_target = 32'h0040_0700;
    ex_pred_taken = 1'b0; ex_pred_next_pc = 32'h0040_0074;
    #1;
    rst_n = 1'b0;
    #1;
    mp("midrst", 1'b0, 4'd0);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("midrst", 32'h0040_0070, 1'b0, 1'b0, 32'h0040_0074);
    mp("midrst_after", 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
